// File: rtl/memory.sv
// Single-port word-addressed RAM on a shared tri-state data bus.
// Reads are combinational; writes land on the rising clock edge.
module memory #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 Reset_N,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  logic [WORD_SIZE-1:0] mem [Depth];
  logic [ADDR_BITS-1:0] idx;
  logic                 rd_en;
  logic                 wr_en;

  // Upper address bits alias onto the decoded window.
  assign idx = address[ADDR_BITS-1:0];

  logic unused_addr;
  assign unused_addr = ^address[WORD_SIZE-1:ADDR_BITS];

  // Simultaneous read and write is illegal and is treated as neither.
  assign rd_en = readM & ~writeM & ~Reset_N;
  assign wr_en = writeM & ~readM;

  // Reset_N is active-high despite its name; it clears every word.
  always_ff @(posedge clk or posedge Reset_N) begin
    if (Reset_N) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= data;
    end
  end

  assign data = rd_en ? mem[idx] : 'z;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus pushes expectations, a monitor pops and checks them.
module tb_memory;

  logic        clk = 1'b0;
  logic        Reset_N = 1'b1;
  logic        readM = 1'b0;
  logic        writeM = 1'b0;
  logic [15:0] address = '0;
  logic        drv_en = 1'b0;
  logic [15:0] drv = '0;
  wire  [15:0] data;

  assign data = drv_en ? drv : 'z;

  memory #(
    .WORD_SIZE(16),
    .ADDR_BITS(8)
  ) dut (
    .clk     (clk),
    .Reset_N (Reset_N),
    .readM   (readM),
    .writeM  (writeM),
    .address (address),
    .data    (data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic        probe = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model [256];

  // Monitor: whenever the stimulus marks the bus as observable, pop and compare.
  always @(negedge clk) begin
    if (probe) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: probe with no expectation, data=%h", data);
      end else begin
        e = sb.pop_front();
        if (data !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, data, e.exp);
        end
      end
    end
  end

  function automatic int unsigned widx(input logic [15:0] a);
    return int'(a) % 256;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
  endtask

  // One bus cycle. A write commits at the following rising edge.
  task automatic op(input logic rd, input logic wr, input logic [15:0] a, input logic den,
                    input logic [15:0] dv, input logic chk, input logic [15:0] exp,
                    input string name);
    exp_t e;
    @(posedge clk);
    #1;
    readM   = rd;
    writeM  = wr;
    address = a;
    drv_en  = den;
    drv     = dv;
    if (wr && !rd && !Reset_N) model[widx(a)] = dv;
    if (chk) begin
      e.name = name;
      e.exp  = exp;
      sb.push_back(e);
      probe = 1'b1;
      @(negedge clk);
      #1;
      probe = 1'b0;
    end
  endtask

  task automatic wr_op(input logic [15:0] a, input logic [15:0] v);
    op(1'b0, 1'b1, a, 1'b1, v, 1'b0, 16'h0, "");
  endtask

  task automatic rd_op(input logic [15:0] a, input string name);
    op(1'b1, 1'b0, a, 1'b0, 16'h0, 1'b1, model[widx(a)], name);
  endtask

  // The DUT must not drive: the bench's own value must appear unaltered.
  task automatic hiz_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] v, input string name);
    op(rd, wr, a, 1'b1, v, 1'b1, v, name);
  endtask

  task automatic idle_op();
    op(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #23;
    Reset_N = 1'b0;

    rd_op(16'h0000, "reset_rd_0000");
    rd_op(16'h0080, "reset_rd_0080");
    rd_op(16'h00FF, "reset_rd_00ff");

    wr_op(16'h0010, 16'hBEEF);
    rd_op(16'h0010, "wr_rd_beef");

    wr_op(16'h0005, 16'h1234);
    rd_op(16'h0105, "alias_0105");

    hiz_op(1'b0, 1'b0, 16'h0010, 16'h5555, "idle_hiz_5555");
    hiz_op(1'b0, 1'b0, 16'h0010, 16'h0000, "idle_hiz_0000");
    hiz_op(1'b1, 1'b1, 16'h0020, 16'h5555, "both_hiz_0020");
    hiz_op(1'b1, 1'b1, 16'h0010, 16'h0000, "both_hiz_0010");
    rd_op(16'h0020, "both_no_write");

    wr_op(16'h0040, 16'h1111);
    wr_op(16'h0040, 16'h2222);
    rd_op(16'h0040, "last_write_wins");
    rd_op(16'h0041, "neighbour_0041");

    // Completed write, then a reset pulse between clock edges.
    wr_op(16'h0030, 16'hAAAA);
    rd_op(16'h0030, "pre_reset_aaaa");
    @(posedge clk);
    #2 Reset_N = 1'b1;
    model_clear();
    #2 Reset_N = 1'b0;
    rd_op(16'h0030, "mid_cycle_reset");
    rd_op(16'h0010, "reset_clears_beef");

    // Write set up, reset rises before the edge and spans it.
    wr_op(16'h0031, 16'h7777);
    #2 Reset_N = 1'b1;
    @(posedge clk);
    #2;
    writeM  = 1'b0;
    drv_en  = 1'b0;
    Reset_N = 1'b0;
    model_clear();
    rd_op(16'h0031, "write_discarded");

    // Release at a falling edge; the very next rising edge takes a write.
    @(posedge clk);
    #1 Reset_N = 1'b1;
    model_clear();
    @(negedge clk);
    #1 Reset_N = 1'b0;
    readM   = 1'b0;
    writeM  = 1'b1;
    address = 16'h0050;
    drv_en  = 1'b1;
    drv     = 16'hC0DE;
    model[widx(16'h0050)] = 16'hC0DE;
    rd_op(16'h0050, "first_edge_write");

    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      logic [15:0] v;
      int unsigned kind;
      a    = 16'($urandom_range(0, 16'hFFFF));
      v    = 16'($urandom_range(0, 16'hFFFF));
      kind = $urandom_range(0, 5);
      if (n < 40) a = {$urandom_range(0, 1) == 0 ? 8'h00 : 8'h01, 5'h0, a[2:0]};
      case (kind)
        0, 1: wr_op(a, v);
        2, 3: rd_op(a, "rand_read");
        4:    hiz_op(1'b0, 1'b0, a, v, "rand_idle_hiz");
        default: hiz_op(1'b1, 1'b1, a, v, "rand_both_hiz");
      endcase
    end
    for (int i = 0; i < 256; i += 17) rd_op(16'(i), "final_sweep");
    idle_op();

    @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
